// File: rtl/cam_ctrl_pkg.sv
// Shared encodings for the password-CAM command controller.
// Contents: command opcodes, response status codes and the controller state enum.
// Imported by cam_ctrl and the bench; no logic lives here.
package cam_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2,
    OP_CLEAR  = 2'd3
  } cam_op_e;

  typedef enum logic [2:0] {
    ST_OK   = 3'd0,
    ST_MISS = 3'd1,
    ST_FULL = 3'd2,
    ST_DUP  = 3'd3,
    ST_BAD  = 3'd4
  } cam_status_e;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_SEARCH,
    S_WAIT,
    S_WRITE,
    S_SWEEP,
    S_RESP
  } cam_state_e;

endpackage

// File: rtl/cam_ctrl_if.sv
// Command/response bundle between the Pass-Keeper front end and cam_ctrl.
// cmd_*: valid/ready command (op, key, delete address); rsp_*: valid/ready response.
// master = front end (drives commands, sinks responses); slave = cam_ctrl.
interface cam_ctrl_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 6
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [2:0]            rsp_status;
  logic [ADDR_WIDTH-1:0] rsp_addr;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_addr, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_status, rsp_addr
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_addr, rsp_ready,
    output cmd_ready, rsp_valid, rsp_status, rsp_addr
  );
endinterface

// File: rtl/cam_free_finder.sv
// Lowest-zero finder over the entry-valid bitmap (combinational, 0 cycles).
// Ports: bitmap in; free_idx = lowest clear bit (0 when full), full = no clear bit.
// No handshake; purely combinational.
module cam_free_finder #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic [2**ADDR_WIDTH-1:0] bitmap,
  output logic [ADDR_WIDTH-1:0]    free_idx,
  output logic                     full
);

  // Scan from the top down so the last hit written is the lowest free index.
  always_comb begin
    free_idx = '0;
    full     = 1'b1;
    for (int i = 2**ADDR_WIDTH - 1; i >= 0; i--) begin
      if (!bitmap[i]) begin
        free_idx = ADDR_WIDTH'(i);
        full     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/cam_ctrl.sv
// Command initiator for the password CAM: LOOKUP/INSERT/DELETE/CLEAR with entry allocation.
// Latency from accept: BAD 1, DELETE 2, LOOKUP/DUP/FULL 2+CAM_LATENCY, INSERT 3+CAM_LATENCY, CLEAR 1+2^AW.
// Backpressure: one command in flight; cmd_ready only in IDLE; response held until rsp_ready.
// Ports: clk/rst (async active-low), bus (cmd/rsp, slave side), occupancy, init_done,
//        cam_start/cam_write_enable/cam_din/cam_write_addr to the CAM, cam_match/cam_match_addr from it.
module cam_ctrl
  import cam_ctrl_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 128,
  parameter int                    ADDR_WIDTH  = 6,
  parameter int                    CAM_LATENCY = 2,
  parameter logic [DATA_WIDTH-1:0] TOMBSTONE   = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  cam_ctrl_if.slave             bus,
  output logic [ADDR_WIDTH:0]   occupancy,
  output logic                  init_done,
  output logic                  cam_start,
  output logic                  cam_write_enable,
  output logic [DATA_WIDTH-1:0] cam_din,
  output logic [ADDR_WIDTH-1:0] cam_write_addr,
  input  logic                  cam_match,
  input  logic [ADDR_WIDTH-1:0] cam_match_addr
);

  localparam int                N           = 2**ADDR_WIDTH;
  localparam int                LW          = $clog2(CAM_LATENCY + 1);
  localparam logic [ADDR_WIDTH:0] NUM_ENTRIES = (ADDR_WIDTH+1)'(N);
  localparam logic [ADDR_WIDTH:0] ONE         = (ADDR_WIDTH+1)'(1);

  cam_state_e            state_q, state_d;
  cam_op_e               op_q, op_d;
  logic [ADDR_WIDTH:0]   sweep_cnt_q, sweep_cnt_d;
  logic [LW-1:0]         lat_cnt_q, lat_cnt_d;
  logic [N-1:0]          bitmap_q, bitmap_d;
  logic [ADDR_WIDTH:0]   occ_q, occ_d;
  logic                  init_done_q, init_done_d;
  cam_status_e           rsp_status_q, rsp_status_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
  logic                  start_q, start_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;

  logic [ADDR_WIDTH-1:0] free_idx;
  logic                  bitmap_full;
  logic                  valid_hit;

  cam_free_finder #(.ADDR_WIDTH(ADDR_WIDTH)) u_free_finder (
    .bitmap   (bitmap_q),
    .free_idx (free_idx),
    .full     (bitmap_full)
  );

  // A CAM match only counts when the entry is allocated; tombstoned or never-written slots are ignored.
  assign valid_hit = cam_match && bitmap_q[cam_match_addr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_INIT;
      op_q         <= OP_LOOKUP;
      sweep_cnt_q  <= '0;
      lat_cnt_q    <= '0;
      bitmap_q     <= '0;
      occ_q        <= '0;
      init_done_q  <= 1'b0;
      rsp_status_q <= ST_OK;
      rsp_addr_q   <= '0;
      start_q      <= 1'b0;
      we_q         <= 1'b0;
      din_q        <= '0;
      waddr_q      <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      sweep_cnt_q  <= sweep_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      bitmap_q     <= bitmap_d;
      occ_q        <= occ_d;
      init_done_q  <= init_done_d;
      rsp_status_q <= rsp_status_d;
      rsp_addr_q   <= rsp_addr_d;
      start_q      <= start_d;
      we_q         <= we_d;
      din_q        <= din_d;
      waddr_q      <= waddr_d;
    end
  end

  // CAM strobes are registered: the value computed here is what the CAM sees next cycle.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    sweep_cnt_d  = sweep_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    bitmap_d     = bitmap_q;
    occ_d        = occ_q;
    init_done_d  = init_done_q;
    rsp_status_d = rsp_status_q;
    rsp_addr_d   = rsp_addr_q;
    start_d      = 1'b0;
    we_d         = 1'b0;
    din_d        = din_q;
    waddr_d      = waddr_q;

    unique case (state_q)
      // sweep_cnt is the next address to tombstone; reaching N means the last write is on the bus now.
      S_INIT, S_SWEEP: begin
        if (sweep_cnt_q == NUM_ENTRIES) begin
          sweep_cnt_d = '0;
          if (state_q == S_INIT) begin
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            bitmap_d     = '0;
            occ_d        = '0;
            rsp_status_d = ST_OK;
            rsp_addr_d   = '0;
            state_d      = S_RESP;
          end
        end else begin
          we_d        = 1'b1;
          waddr_d     = sweep_cnt_q[ADDR_WIDTH-1:0];
          din_d       = TOMBSTONE;
          sweep_cnt_d = sweep_cnt_q + ONE;
        end
      end

      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d = cam_op_e'(bus.cmd_op);
          unique case (cam_op_e'(bus.cmd_op))
            OP_LOOKUP, OP_INSERT: begin
              if (bus.cmd_data == TOMBSTONE) begin
                rsp_status_d = ST_BAD;
                rsp_addr_d   = '0;
                state_d      = S_RESP;
              end else begin
                start_d = 1'b1;
                din_d   = bus.cmd_data;
                state_d = S_SEARCH;
              end
            end
            OP_DELETE: begin
              // Both outcomes pass through WRITE so DELETE latency is fixed; only a hit pulses the write.
              rsp_addr_d = '0;
              if (bitmap_q[bus.cmd_addr]) begin
                we_d                   = 1'b1;
                waddr_d                = bus.cmd_addr;
                din_d                  = TOMBSTONE;
                bitmap_d[bus.cmd_addr] = 1'b0;
                occ_d                  = occ_q - ONE;
                rsp_status_d           = ST_OK;
              end else begin
                rsp_status_d = ST_MISS;
              end
              state_d = S_WRITE;
            end
            OP_CLEAR: begin
              // Address 0 goes out with the accept so the sweep finishes at accept+2^AW.
              we_d        = 1'b1;
              waddr_d     = '0;
              din_d       = TOMBSTONE;
              sweep_cnt_d = ONE;
              state_d     = S_SWEEP;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end

      S_SEARCH: begin
        lat_cnt_d = LW'(1);
        state_d   = S_WAIT;
      end

      S_WAIT: begin
        if (lat_cnt_q == LW'(CAM_LATENCY)) begin
          if (op_q == OP_LOOKUP) begin
            rsp_status_d = valid_hit ? ST_OK : ST_MISS;
            rsp_addr_d   = valid_hit ? cam_match_addr : '0;
            state_d      = S_RESP;
          end else if (valid_hit) begin
            rsp_status_d = ST_DUP;
            rsp_addr_d   = cam_match_addr;
            state_d      = S_RESP;
          end else if (bitmap_full) begin
            rsp_status_d = ST_FULL;
            rsp_addr_d   = '0;
            state_d      = S_RESP;
          end else begin
            // cam_din still holds the key from the search cycle.
            we_d               = 1'b1;
            waddr_d            = free_idx;
            bitmap_d[free_idx] = 1'b1;
            occ_d              = occ_q + ONE;
            rsp_status_d       = ST_OK;
            rsp_addr_d         = free_idx;
            state_d            = S_WRITE;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + LW'(1);
        end
      end

      S_WRITE: state_d = S_RESP;

      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end

      default: state_d = S_INIT;
    endcase
  end

  assign bus.cmd_ready    = (state_q == S_IDLE);
  assign bus.rsp_valid    = (state_q == S_RESP);
  assign bus.rsp_status   = rsp_status_q;
  assign bus.rsp_addr     = rsp_addr_q;
  assign occupancy        = occ_q;
  assign init_done        = init_done_q;
  assign cam_start        = start_q;
  assign cam_write_enable = we_q;
  assign cam_din          = din_q;
  assign cam_write_addr   = waddr_q;

endmodule

// File: tb/tb_cam_ctrl.sv
// Bench for cam_ctrl: behavioural CAM + entry-table reference model, directed then random commands.
// Checks status, address, latency, CAM write/start traffic, occupancy and response hold.
// Ends with one summary line.
module tb_cam_ctrl;
  import cam_ctrl_pkg::*;

  localparam int DW = 128;
  localparam int AW = 6;
  localparam int L  = 2;
  localparam int N  = 64;
  localparam logic [DW-1:0] ONES = '1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cam_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  logic [AW:0]   occupancy;
  logic          init_done;
  logic          cam_start;
  logic          cam_write_enable;
  logic [DW-1:0] cam_din;
  logic [AW-1:0] cam_write_addr;
  logic          cam_match;
  logic [AW-1:0] cam_match_addr;

  cam_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAM_LATENCY(L), .TOMBSTONE(ONES)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .occupancy        (occupancy),
    .init_done        (init_done),
    .cam_start        (cam_start),
    .cam_write_enable (cam_write_enable),
    .cam_din          (cam_din),
    .cam_write_addr   (cam_write_addr),
    .cam_match        (cam_match),
    .cam_match_addr   (cam_match_addr)
  );

  // Behavioural CAM: contents follow the write port; match is lowest address equal to the last search key.
  logic [DW-1:0] cam_mem [N];
  logic [DW-1:0] search_key;
  logic          ghost_en;
  logic [AW-1:0] ghost_addr;

  always_comb begin
    cam_match      = 1'b0;
    cam_match_addr = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cam_mem[i] == search_key) begin
        cam_match      = 1'b1;
        cam_match_addr = AW'(i);
      end
    end
    if (ghost_en && !cam_match) begin
      cam_match      = 1'b1;
      cam_match_addr = ghost_addr;
    end
  end

  // Monitor: records every write and start pulse seen by the CAM.
  int            cyc         = 0;
  int            start_cnt   = 0;
  int            overlap_cnt = 0;
  logic [AW-1:0] wr_addr_q [$];
  logic [DW-1:0] wr_dat_q  [$];
  int            wr_cyc_q  [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      search_key <= '0;
      for (int i = 0; i < N; i++) cam_mem[i] <= {$urandom, $urandom, $urandom, $urandom};
    end else begin
      if (cam_write_enable) begin
        cam_mem[cam_write_addr] <= cam_din;
        wr_addr_q.push_back(cam_write_addr);
        wr_dat_q.push_back(cam_din);
        wr_cyc_q.push_back(cyc);
      end
      if (cam_start) begin
        search_key <= cam_din;
        start_cnt  <= start_cnt + 1;
      end
      if (cam_start && cam_write_enable) overlap_cnt <= overlap_cnt + 1;
    end
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Reference model: which slots hold which key.
  logic [DW-1:0] m_key [N];
  logic          m_vld [N];
  int            m_occ;

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
    m_occ = 0;
  endtask

  function automatic int sweep_errs(input int w0);
    int e = 0;
    if (wr_addr_q.size() < w0 + N) return N;
    for (int i = 0; i < N; i++) begin
      if (wr_addr_q[w0+i] != AW'(i)) e++;
      if (wr_dat_q[w0+i] != ONES) e++;
      if (wr_cyc_q[w0+i] != wr_cyc_q[w0] + i) e++;
    end
    return e;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_strobes"}, {cam_start, cam_write_enable, init_done, bus.cmd_ready, bus.rsp_valid}, 0);
    chk({tag, "_din"}, cam_din, 0);
    chk({tag, "_waddr"}, cam_write_addr, 0);
    chk({tag, "_occ"}, occupancy, 0);
    chk({tag, "_rsp"}, {bus.rsp_status, bus.rsp_addr}, 0);
  endtask

  task automatic wait_init(input string tag, input int w0);
    int k = 0;
    while (init_done !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_init_done"}, init_done, 1);
    chk({tag, "_sweep_cnt"}, wr_addr_q.size() - w0, N);
    chk({tag, "_sweep_errs"}, sweep_errs(w0), 0);
    chk({tag, "_ready_occ"}, {bus.cmd_ready, occupancy}, {1'b1, 7'd0});
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [DW-1:0] data, input logic [AW-1:0] addr,
                        input logic use_ghost, input int hold);
    int            hit_i, free_i, e_st, e_addr, e_lat, e_starts, e_wr, w0, s0, k, g;
    logic [AW-1:0] e_wa;
    logic [DW-1:0] e_wd;
    hit_i = -1;
    free_i = -1;
    for (int i = N - 1; i >= 0; i--) begin
      if (m_vld[i] && m_key[i] == data) hit_i = i;
      if (!m_vld[i]) free_i = i;
    end
    e_st = ST_OK; e_addr = 0; e_lat = 0; e_starts = 0; e_wr = 0; e_wa = '0; e_wd = ONES;
    ghost_en = 1'b0;
    case (op)
      OP_LOOKUP, OP_INSERT: begin
        if (data == ONES) begin
          e_st = ST_BAD; e_lat = 1;
        end else begin
          e_starts = 1;
          e_lat = 2 + L;
          if (op == OP_LOOKUP) begin
            if (hit_i >= 0) e_addr = hit_i; else e_st = ST_MISS;
          end else if (hit_i >= 0) begin
            e_st = ST_DUP; e_addr = hit_i;
          end else if (free_i < 0) begin
            e_st = ST_FULL;
          end else begin
            e_lat = 3 + L; e_addr = free_i; e_wr = 1; e_wa = AW'(free_i); e_wd = data;
            m_vld[free_i] = 1'b1; m_key[free_i] = data; m_occ++;
          end
          // Phantom match on an unallocated slot must be ignored by the controller.
          if (use_ghost && hit_i < 0 && free_i >= 0) begin
            g = $urandom_range(0, N - 1);
            for (int t = 0; t < 200 && (m_vld[g] || g == free_i); t++) g = $urandom_range(0, N - 1);
            if (!m_vld[g] && g != free_i) begin
              ghost_addr = AW'(g);
              ghost_en   = 1'b1;
            end
          end
        end
      end
      OP_DELETE: begin
        e_lat = 2;
        if (m_vld[addr]) begin
          e_wr = 1; e_wa = addr; m_vld[addr] = 1'b0; m_occ--;
        end else begin
          e_st = ST_MISS;
        end
      end
      default: begin
        e_lat = 1 + N; e_wr = N;
        model_clear();
      end
    endcase

    k = 0;
    while (bus.cmd_ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    w0 = wr_addr_q.size();
    s0 = start_cnt;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.cmd_addr  = addr;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    k = 1;
    while (bus.rsp_valid !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("rsp_latency", k, e_lat);
    chk("rsp_status", bus.rsp_status, e_st);
    chk("rsp_addr", bus.rsp_addr, e_addr);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("rsp_hold", {bus.cmd_ready, bus.rsp_valid, bus.rsp_status, bus.rsp_addr},
          {1'b0, 1'b1, 3'(e_st), AW'(e_addr)});
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    ghost_en = 1'b0;
    chk("rsp_retire", {bus.cmd_ready, bus.rsp_valid}, 2'b10);
    chk("wr_count", wr_addr_q.size() - w0, e_wr);
    if (e_wr == 1 && wr_addr_q.size() > w0) begin
      chk("wr_addr", wr_addr_q[w0], e_wa);
      chk("wr_data", wr_dat_q[w0], e_wd);
    end
    if (e_wr == N) chk("clear_sweep_errs", sweep_errs(w0), 0);
    chk("start_count", start_cnt - s0, e_starts);
    chk("occupancy", occupancy, m_occ);
  endtask

  logic [DW-1:0] key;
  int            r;
  int            w0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = '0;
    bus.cmd_addr  = '0;
    bus.rsp_ready = 1'b0;
    ghost_en      = 1'b0;
    ghost_addr    = '0;
    model_clear();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    w0 = wr_addr_q.size();
    rst = 1'b1;
    wait_init("init", w0);

    // Directed scenarios.
    do_cmd(OP_INSERT, 128'h1111, '0, 1'b0, 0);
    do_cmd(OP_INSERT, 128'h1111, '0, 1'b0, 0);
    do_cmd(OP_LOOKUP, 128'h1111, '0, 1'b0, 0);
    do_cmd(OP_LOOKUP, 128'h2222, '0, 1'b0, 0);
    do_cmd(OP_DELETE, '0, 6'd0, 1'b0, 0);
    do_cmd(OP_DELETE, '0, 6'd0, 1'b0, 0);
    do_cmd(OP_LOOKUP, 128'h1111, '0, 1'b0, 0);
    for (int i = 0; i < N; i++) do_cmd(OP_INSERT, 128'h1000 + DW'(i), '0, 1'b0, 0);
    do_cmd(OP_INSERT, 128'h9999, '0, 1'b0, 0);
    do_cmd(OP_INSERT, ONES, '0, 1'b0, 0);
    do_cmd(OP_LOOKUP, ONES, '0, 1'b0, 0);
    do_cmd(OP_LOOKUP, 128'h1005, '0, 1'b0, 5);
    do_cmd(OP_DELETE, '0, 6'd17, 1'b0, 2);
    do_cmd(OP_INSERT, 128'h7777, '0, 1'b0, 0);
    do_cmd(OP_CLEAR, '0, '0, 1'b0, 0);
    do_cmd(OP_LOOKUP, 128'h1005, '0, 1'b1, 0);

    // Random traffic over a small key pool so hits, dups and deletes of live entries are common.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      key = 128'h5000 + DW'($urandom_range(0, 79));
      if ($urandom_range(0, 31) == 0) key = ONES;
      if (r < 40)      do_cmd(OP_INSERT, key, '0, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      else if (r < 68) do_cmd(OP_LOOKUP, key, '0, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      else if (r < 97) do_cmd(OP_DELETE, '0, AW'($urandom_range(0, N - 1)), 1'b0, $urandom_range(0, 2));
      else             do_cmd(OP_CLEAR, '0, '0, 1'b0, 0);
    end

    // Reset while a LOOKUP is waiting on the CAM.
    do_cmd(OP_INSERT, 128'h4242, '0, 1'b0, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_LOOKUP;
    bus.cmd_data  = 128'h4242;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    chk_reset_vals("midrst_hold");
    model_clear();
    w0 = wr_addr_q.size();
    rst = 1'b1;
    wait_init("reinit", w0);
    do_cmd(OP_LOOKUP, 128'h4242, '0, 1'b0, 0);

    chk("start_we_overlap", overlap_cnt, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/cam_ctrl.md
Name: cam_ctrl

Overview:
- Command-side initiator for the password CAM. It drives the CAM's start/din/write_enable/write_addr and consumes match/match_addr.
- Offers a valid/ready command port (LOOKUP, INSERT, DELETE, CLEAR) and a valid/ready response port to the Pass-Keeper front end.
- Owns entry allocation via a valid bitmap. Overwrites freed and uninitialised entries with a tombstone value so stale data never matches.

Parameters:
- DATA_WIDTH, 128, CAM search/write data width.
- ADDR_WIDTH, 6, log2 of CAM entries (64).
- CAM_LATENCY, 2, cycles from the start pulse to the cycle match/match_addr are sampled (min 1).
- TOMBSTONE, all ones (DATA_WIDTH bits), value written to empty entries; illegal as user data.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller accepts a command this cycle.
- cmd_op  in  2  00 LOOKUP, 01 INSERT, 10 DELETE, 11 CLEAR.
- cmd_data  in  DATA_WIDTH  key for LOOKUP/INSERT.
- cmd_addr  in  ADDR_WIDTH  entry for DELETE.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_status  out  3  0 OK/HIT, 1 MISS, 2 FULL, 3 DUP, 4 BAD.
- rsp_addr  out  ADDR_WIDTH  hit, new, or duplicate address; 0 otherwise.
- occupancy  out  ADDR_WIDTH+1  number of valid entries.
- init_done  out  1  high once the post-reset sweep completes.
- cam_start  out  1  one-cycle search pulse.
- cam_write_enable  out  1  one-cycle write pulse.
- cam_din  out  DATA_WIDTH  search/write data to the CAM.
- cam_write_addr  out  ADDR_WIDTH  write address.
- cam_match  in  1  CAM match flag.
- cam_match_addr  in  ADDR_WIDTH  CAM matched address.

Behaviour:
- Reset (rst=0, async): state INIT, sweep counter 0, bitmap 0, occupancy 0, init_done 0, cmd_ready 0, rsp_valid 0, rsp_status 0, rsp_addr 0, cam_start 0, cam_write_enable 0, cam_din 0, cam_write_addr 0.
- States: INIT, IDLE, SEARCH, WAIT, WRITE, SWEEP, RESP.
- INIT/SWEEP: write TOMBSTONE to addresses 0..2^AW-1, one per cycle (64 cycles). INIT then goes to IDLE and sets init_done. SWEEP clears the bitmap, then goes to RESP with OK.
- cmd_ready = 1 only in IDLE. Accept cycle is t.
- LOOKUP/INSERT with cmd_data == TOMBSTONE: no CAM activity; RESP at t+1 with BAD.
- LOOKUP: cam_start=1 and cam_din=cmd_data at t+1. Sample match at t+1+CAM_LATENCY. RESP at t+2+CAM_LATENCY.
  - HIT with rsp_addr=match_addr if match and bitmap[match_addr]=1.
  - Otherwise MISS with rsp_addr=0.
- INSERT: same search first.
  - Valid match: DUP with the existing address.
  - Else bitmap full: FULL.
  - Else WRITE at t+2+L: write_enable, addr = lowest zero bitmap bit, din=cmd_data. Set that bit, occupancy+1. RESP at t+3+L with OK and the new address.
- DELETE: if bitmap[cmd_addr]=1, write TOMBSTONE at t+1, clear the bit, occupancy-1, then OK. Else MISS with no write. RESP at t+2 either way.
- CLEAR: SWEEP as above. RESP at t+1+2^AW.
- RESP: rsp_valid held with status/addr stable until rsp_ready. The handshake cycle returns to IDLE, so the next accept is possible one cycle later.
- cam_start and cam_write_enable are never high together and are never high outside the cycles stated above.
- The CAM is assumed insensitive to din while idle. cam_din holds its last value.
- Reset mid-operation aborts everything and restarts INIT. Any in-flight response is dropped.

Decomposition:
- Package cam_ctrl_pkg holds the op encodings, status encodings, and state enum.
- Sub-module cam_free_finder: combinational lowest-zero finder over the 2^AW bitmap, producing index and full flag.

Test Plan:
- Reset release -> cam_write_enable high for exactly 64 consecutive cycles, addresses 0..63, din all ones; then init_done=1, cmd_ready=1, occupancy=0.
- INSERT 0x...1111 -> cam_start pulse, one write to addr 0, OK/addr 0. Repeat INSERT 0x...1111 (CAM drives match=1, addr 0) -> DUP/addr 0, no write.
- LOOKUP 0x...1111 with match at addr 0 -> HIT/0 at accept+4. LOOKUP 0x...2222 with match=0 -> MISS/0.
- DELETE addr 0 -> TOMBSTONE write to addr 0, OK, occupancy 0. Second DELETE addr 0 -> MISS, no write.
- 64 distinct inserts -> addresses 0..63 and occupancy 64; 65th insert -> FULL. Insert with data all ones -> BAD at accept+1, no CAM pulses.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid and fields stable, cmd_ready=0. Assert rst mid-WAIT -> all outputs return to reset values and the INIT sweep restarts.
